// File: rtl/bm_infer_sched_if.sv
// bm_infer_sched_if
//   Observation-in / result-out handshake bundle of the Bayesian machine
//   inference scheduler.
//   obs_valid/obs_ready/obs_data : requester -> scheduler job queue (36-bit job)
//   res_valid/res_ready/res_data : scheduler -> consumer result word (32-bit)
//   modport master : requester / consumer side
//   modport slave  : scheduler side
interface bm_infer_sched_if;
  logic        obs_valid;
  logic        obs_ready;
  logic [35:0] obs_data;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;

  modport master (
    output obs_valid, obs_data, res_ready,
    input  obs_ready, res_valid, res_data
  );

  modport slave (
    input  obs_valid, obs_data, res_ready,
    output obs_ready, res_valid, res_data
  );
endinterface

// File: rtl/bm_infer_sched.sv
// bm_infer_sched
//   Queues observation jobs and runs one read pass per observation block
//   (four per job) on the Bayesian stochastic/log machine, then shifts out
//   four 8-bit class counts and returns them as one 32-bit result word.
//
// Ports
//   clk, rst      clock; synchronous active-high reset
//   bus (slave)   obs_* job push channel, res_* result channel
//   busy          scheduler active or queue non-empty
//   bm_*          machine control pins and row/column address (registered)
//   bm_bit_out    per-class output bits sampled during readout
//
// Configuration
//   BM_SCHED_PERF_EN  adds perf_jobs (result handshakes) and perf_stall
//                     (DONE cycles with res_ready low), both saturating.
module bm_infer_sched #(
  parameter int FIFO_DEPTH   = 4,   // power of two, >= 2
  parameter int PULSE_CYCLES = 2    // 1..255
) (
  input  logic                   clk,
  input  logic                   rst,
  bm_infer_sched_if.slave        bus,
  output logic                   busy,
  output logic                   bm_csl,
  output logic                   bm_cwl,
  output logic                   bm_read_8,
  output logic                   bm_inference,
  output logic                   bm_read_out,
  output logic                   bm_load_mem,
  output logic                   bm_stoch_log,
  output logic [7:0]             bm_adr_col,
  output logic [7:0]             bm_adr_row,
  input  logic [3:0]             bm_bit_out
`ifdef BM_SCHED_PERF_EN
  ,
  output logic [15:0]            perf_jobs,
  output logic [15:0]            perf_stall
`endif
);

  localparam int           AW         = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]  PTR_ONE    = (AW + 1)'(1);
  localparam logic [7:0]   PULSE_LAST = 8'(PULSE_CYCLES - 1);
  localparam logic [7:0]   WAIT_LAST  = 8'd2;
  localparam logic [7:0]   SHIFT_LAST = 8'd7;

  typedef enum logic [3:0] {
    IDLE, SETUP, PRECHARGE, PULSE, OFF, OUT_WAIT, OUT_SHIFT, ZERO, DONE
  } state_e;

  typedef struct packed {
    logic       csl;
    logic       cwl;
    logic       read_8;
    logic       inference;
    logic       read_out;
    logic       load_mem;
    logic       stoch_log;
    logic       res_valid;
    logic [7:0] adr_col;
    logic [7:0] adr_row;
  } pins_t;

  // Pin image for a given state; used on next-state values so the pins are
  // registered yet line up with the state they describe.
  function automatic pins_t decode(state_e s, logic [1:0] pass, logic [35:0] job);
    pins_t      p;
    logic [8:0] obs;
    logic       in_pass;
    logic       in_read;
    p       = '0;
    obs     = job[9*pass +: 9];
    in_pass = (s == SETUP) || (s == PRECHARGE) || (s == PULSE) || (s == OFF);
    in_read = (s == OUT_WAIT) || (s == OUT_SHIFT);
    p.csl   = (s == PRECHARGE);
    p.cwl   = (s == PRECHARGE) || (s == PULSE);
    // Mode pins rise at the first PRECHARGE and stay up across the later
    // SETUPs; inference joins at the first OFF.
    p.stoch_log = (in_pass && !(s == SETUP && pass == 2'd0)) || in_read;
    p.read_8    = p.stoch_log;
    p.inference = (in_pass && (pass != 2'd0 || s == OFF)) || in_read;
    p.read_out  = in_read;
    p.load_mem  = (s == ZERO);
    p.res_valid = (s == DONE);
    // Readout keeps the pass-3 address since pass stays at 3.
    if (in_pass || in_read) begin
      p.adr_col = {pass, 3'b000, obs[2:0]};
      p.adr_row = {2'b00, obs[8:3]};
    end
    return p;
  endfunction

  state_e      state_q, state_d;
  logic [1:0]  pass_q, pass_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [35:0] job_q, job_d;
  logic [31:0] res_q, res_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  pins_t       pins_q;
  logic        busy_q;
  logic [35:0] fifo_mem [FIFO_DEPTH];
  logic        full, empty, push, pop;

  assign full          = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                         (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty         = (wr_ptr_q == rd_ptr_q);
  assign bus.obs_ready = !full && !rst;
  assign push          = bus.obs_valid && bus.obs_ready;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    state_d = state_q;
    pass_d  = pass_q;
    cnt_d   = cnt_q;
    job_d   = job_q;
    res_d   = res_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: if (!empty) begin
        pop     = 1'b1;
        job_d   = fifo_mem[rd_ptr_q[AW-1:0]];
        pass_d  = 2'd0;
        res_d   = '0;
        state_d = SETUP;
      end
      SETUP:     state_d = PRECHARGE;
      PRECHARGE: begin
        state_d = PULSE;
        cnt_d   = '0;
      end
      PULSE: if (cnt_q == PULSE_LAST) begin
        state_d = OFF;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
      OFF: if (pass_q != 2'd3) begin
        pass_d  = pass_q + 2'd1;
        state_d = SETUP;
      end else begin
        state_d = OUT_WAIT;
        cnt_d   = '0;
      end
      OUT_WAIT: if (cnt_q == WAIT_LAST) begin
        state_d = OUT_SHIFT;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
      OUT_SHIFT: begin
        // First bit shifted in ends up in bit 7 of each class byte.
        for (int k = 0; k < 4; k++) begin
          res_d[8*k +: 8] = {res_q[8*k +: 7], bm_bit_out[k]};
        end
        if (cnt_q == SHIFT_LAST) begin
          state_d = ZERO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ZERO: state_d = DONE;
      DONE: if (bus.res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q  <= IDLE;
      pass_q   <= '0;
      cnt_q    <= '0;
      job_q    <= '0;
      res_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      pins_q   <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pass_q   <= pass_d;
      cnt_q    <= cnt_d;
      job_q    <= job_d;
      res_q    <= res_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      pins_q   <= decode(state_d, pass_d, job_d);
      busy_q   <= (state_d != IDLE) || (wr_ptr_d != rd_ptr_d);
    end
  end

  // NOTE: queue storage has no reset; the pointers alone say which entries
  // are live, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q[AW-1:0]] <= bus.obs_data;
  end

  assign bus.res_valid = pins_q.res_valid;
  assign bus.res_data  = res_q;
  assign busy          = busy_q;
  assign bm_csl        = pins_q.csl;
  assign bm_cwl        = pins_q.cwl;
  assign bm_read_8     = pins_q.read_8;
  assign bm_inference  = pins_q.inference;
  assign bm_read_out   = pins_q.read_out;
  assign bm_load_mem   = pins_q.load_mem;
  assign bm_stoch_log  = pins_q.stoch_log;
  assign bm_adr_col    = pins_q.adr_col;
  assign bm_adr_row    = pins_q.adr_row;

`ifdef BM_SCHED_PERF_EN
  logic [15:0] perf_jobs_q, perf_stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_jobs_q  <= '0;
      perf_stall_q <= '0;
    end else if (state_q == DONE) begin
      if (bus.res_ready) begin
        if (perf_jobs_q != 16'hFFFF) perf_jobs_q <= perf_jobs_q + 16'd1;
      end else begin
        if (perf_stall_q != 16'hFFFF) perf_stall_q <= perf_stall_q + 16'd1;
      end
    end
  end

  assign perf_jobs  = perf_jobs_q;
  assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_bm_infer_sched.sv
// tb_bm_infer_sched
//   Self-checking bench for bm_infer_sched. A cycle-level reference model
//   expands each job into its list of expected pin vectors (phase table),
//   keeps its own job queue, and assembles the expected result word from the
//   bits the bench drove during readout. Directed scenarios add constant
//   checks for latency, addressing, bit order, queue full, reset and perf.
module tb_bm_infer_sched;
  localparam int DEPTH = 4;
  localparam int PC    = 2;
  localparam int LAT   = 14 + 4 * (3 + PC);

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] bit_out;
  logic       busy, csl, cwl, r8, inf, ro, lm, sl;
  logic [7:0] col, row;
`ifdef BM_SCHED_PERF_EN
  logic [15:0] perf_jobs, perf_stall;
`endif

  always #5 clk = ~clk;

  bm_infer_sched_if bus_if();

  bm_infer_sched #(.FIFO_DEPTH(DEPTH), .PULSE_CYCLES(PC)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus_if),
    .busy         (busy),
    .bm_csl       (csl),
    .bm_cwl       (cwl),
    .bm_read_8    (r8),
    .bm_inference (inf),
    .bm_read_out  (ro),
    .bm_load_mem  (lm),
    .bm_stoch_log (sl),
    .bm_adr_col   (col),
    .bm_adr_row   (row),
    .bm_bit_out   (bit_out)
`ifdef BM_SCHED_PERF_EN
    ,
    .perf_jobs    (perf_jobs),
    .perf_stall   (perf_stall)
`endif
  );

  typedef struct packed {
    logic csl, cwl, r8, inf, ro, lm, sl;
    logic [7:0] col, row;
    logic shift;
  } step_t;

  step_t       plan[$];
  logic [35:0] mq[$];
  logic [35:0] to_send[$];
  logic [3:0]  got [8];
  logic [31:0] exp_word;
  int phase, n_shift, done_cnt, cyc, checks, errors;
  int push_gap, ready_mode, bit_mode, bit_sel, dut_acc;
  int n_csl, n_cwl, n_lm, n_rv, t0;
  logic rst_req, dir_on;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  // Phase table of one job: per pass SETUP, PRECHARGE, PULSE x PC, OFF;
  // then OUT_WAIT x3, OUT_SHIFT x8, ZERO.
  task automatic build_plan(input logic [35:0] job);
    step_t      s;
    logic [8:0] o;
    plan.delete();
    s = '0;
    for (int p = 0; p < 4; p++) begin
      o     = job[9*p +: 9];
      s     = '0;
      s.col = {2'(p), 3'b000, o[2:0]};
      s.row = {2'b00, o[8:3]};
      s.r8  = (p != 0);
      s.sl  = (p != 0);
      s.inf = (p != 0);
      plan.push_back(s);
      s.csl = 1'b1; s.cwl = 1'b1; s.r8 = 1'b1; s.sl = 1'b1;
      plan.push_back(s);
      s.csl = 1'b0;
      for (int i = 0; i < PC; i++) plan.push_back(s);
      s.cwl = 1'b0; s.inf = 1'b1;
      plan.push_back(s);
    end
    s.ro = 1'b1;
    for (int i = 0; i < 3; i++) plan.push_back(s);
    s.shift = 1'b1;
    for (int i = 0; i < 8; i++) plan.push_back(s);
    s = '0;
    s.lm = 1'b1;
    plan.push_back(s);
  endtask

  function automatic logic [23:0] exp_pins();
    if (phase == 1)
      return {plan[0].csl, plan[0].cwl, plan[0].r8, plan[0].inf, plan[0].ro,
              plan[0].lm, plan[0].sl, 1'b0, plan[0].col, plan[0].row};
    if (phase == 2) return {7'b0, 1'b1, 16'h0000};
    return 24'h0;
  endfunction

  // One clock cycle: compare outputs, drive inputs, advance model.
  task automatic cycle();
    logic [3:0]  bits;
    logic        valid, ready, shift_now;
    logic [35:0] d;
    int          b;
    check("pins", {csl, cwl, r8, inf, ro, lm, sl, bus_if.res_valid, col, row}, exp_pins());
    check("obs_ready", bus_if.obs_ready, !rst && (mq.size() < DEPTH));
    check("busy", busy, (phase != 0) || (mq.size() != 0));
    if (phase == 2) check("res_data", bus_if.res_data, exp_word);
    if (dir_on && cyc == t0 + 2) check("addr_pass0", {col, row}, 16'h0301);
    if (dir_on && cyc == t0 + 2 + 3 * (3 + PC)) check("col_pass3", col, 8'hC3);
    n_csl += csl; n_cwl += cwl; n_lm += lm; n_rv += bus_if.res_valid;

    rst       = rst_req;
    rst_req   = 1'b0;
    shift_now = (phase == 1) && plan[0].shift;
    if (bit_mode == 0)      bits = 4'($urandom);
    else if (bit_mode == 1) bits = 4'b1010;
    else                    bits = (shift_now && n_shift + 1 == bit_sel) ? 4'b0001 : 4'b0000;
    if (ready_mode == 0)      ready = 1'b0;
    else if (ready_mode == 1) ready = 1'($urandom_range(0, 1));
    else if (ready_mode == 2) ready = (done_cnt >= 5);
    else                      ready = 1'b1;
    valid = !rst && (to_send.size() != 0) &&
            (push_gap == 0 || $urandom_range(0, push_gap) == 0);
    d = valid ? to_send[0] : {4'($urandom), $urandom};
    bus_if.obs_valid = valid;
    bus_if.obs_data  = d;
    bus_if.res_ready = ready;
    bit_out          = bits;
    #1;
    if (valid && bus_if.obs_ready) dut_acc++;

    if (rst) begin
      mq.delete(); to_send.delete(); plan.delete();
      phase = 0; done_cnt = 0;
    end else begin
      logic acc;
      acc = valid && (mq.size() < DEPTH);
      case (phase)
        0: if (mq.size() != 0) begin
          build_plan(mq.pop_front());
          phase = 1; n_shift = 0;
        end
        1: begin
          if (plan[0].shift) begin got[n_shift] = bits; n_shift++; end
          void'(plan.pop_front());
          if (plan.size() == 0) begin
            for (int k = 0; k < 4; k++) begin
              b = 0;
              for (int i = 0; i < 8; i++) b += int'(got[i][k]) * (1 << (7 - i));
              exp_word[8*k +: 8] = 8'(b);
            end
            phase = 2; done_cnt = 0;
          end
        end
        default: if (ready) phase = 0; else done_cnt++;
      endcase
      if (acc) begin mq.push_back(d); void'(to_send.pop_front()); end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while ((to_send.size() != 0 || mq.size() != 0 || phase != 0) && k < budget) begin
      cycle(); k++;
    end
    check("drain_in_budget", k < budget, 1'b1);
  endtask

  task automatic wait_valid(input int budget);
    int k;
    k = 0;
    while (!bus_if.res_valid && k < budget) begin cycle(); k++; end
    check("res_valid_seen", bus_if.res_valid, 1'b1);
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; phase = 0; n_shift = 0; done_cnt = 0;
    push_gap = 0; ready_mode = 3; bit_mode = 1; bit_sel = 0; dut_acc = 0;
    n_csl = 0; n_cwl = 0; n_lm = 0; n_rv = 0; t0 = 0;
    rst_req = 1'b0; dir_on = 1'b0; exp_word = '0;
    rst = 1'b1; bit_out = '0;
    bus_if.obs_valid = 1'b0; bus_if.obs_data = '0; bus_if.res_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_res_data", bus_if.res_data, 32'h0);
    check("rst_obs_ready", bus_if.obs_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    run(2);

    // Single job: latency, addressing, pin counts, held 1010 bits.
    to_send.push_back({4{9'h00B}});
    t0 = cyc; dir_on = 1'b1;
    n_csl = 0; n_cwl = 0; n_lm = 0;
    wait_valid(100);
    dir_on = 1'b0;
    check("latency", cyc - t0, LAT);
    check("res_1010", bus_if.res_data, 32'hFF00FF00);
    check("csl_cycles", n_csl, 4);
    check("cwl_cycles", n_cwl, 4 * (1 + PC));
    check("load_mem_cycles", n_lm, 1);
    run(2);

    // Bit ordering: single one on shift cycle 1, then on shift cycle 8.
    bit_mode = 2; bit_sel = 1;
    to_send.push_back({4'($urandom), $urandom});
    wait_valid(100);
    check("order_first", bus_if.res_data, 32'h0000_0080);
    run(2);
    bit_sel = 8;
    to_send.push_back({4'($urandom), $urandom});
    wait_valid(100);
    check("order_last", bus_if.res_data, 32'h0000_0001);
    run(2);

    // Queue full with the consumer stalled.
    bit_mode = 0; ready_mode = 0; dut_acc = 0;
    for (int i = 0; i < 6; i++) to_send.push_back({4'($urandom), $urandom});
    run(10);
    check("q_full_ready", bus_if.obs_ready, 1'b0);
    check("q_accepts", dut_acc, 5);
    ready_mode = 1;
    drain(1500);

    // Reset during readout of job 1 with two jobs queued.
    ready_mode = 3;
    for (int i = 0; i < 3; i++) to_send.push_back({4'($urandom), $urandom});
    for (int k = 0; k < 100 && !(phase == 1 && plan[0].shift && mq.size() == 2); k++) cycle();
    check("reached_shift", phase == 1 && mq.size() == 2, 1'b1);
    rst_req = 1'b1;
    cycle();
    check("rst_pins_zero", {csl, cwl, r8, inf, ro, lm, sl, bus_if.res_valid, col, row}, 24'h0);
    check("rst_busy_zero", busy, 1'b0);
    check("rst_data_zero", bus_if.res_data, 32'h0);
    n_rv = 0;
    run(60);
    check("no_flushed_result", n_rv, 0);

    // Random traffic with gaps, random backpressure, random machine bits.
    bit_mode = 0; ready_mode = 1; push_gap = 3;
    for (int i = 0; i < 20; i++) to_send.push_back({4'($urandom), $urandom});
    drain(3000);

`ifdef BM_SCHED_PERF_EN
    rst_req = 1'b1;
    cycle();
    ready_mode = 2; push_gap = 0;
    for (int i = 0; i < 3; i++) to_send.push_back({4'($urandom), $urandom});
    drain(500);
    check("perf_jobs", perf_jobs, 16'd3);
    check("perf_stall", perf_stall, 16'd15);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
